// File: rtl/uart_core_if.sv
// Host-side parallel bus of uart_core: write/read strobes, data and status flags.
// master = host, slave = the UART core.
interface uart_core_if;
  logic       read;
  logic       write;
  logic [7:0] datain;
  logic [7:0] dataout;
  logic       rxrdy;
  logic       txrdy;
  logic       parityerr;
  logic       framingerr;
  logic       overrun;

  modport master (
    output read, write, datain,
    input  dataout, rxrdy, txrdy, parityerr, framingerr, overrun
  );

  modport slave (
    input  read, write, datain,
    output dataout, rxrdy, txrdy, parityerr, framingerr, overrun
  );
endinterface

// File: rtl/uart_core.sv
// Full-duplex 8-bit UART on a 16x-baud clock, one stop bit.
// Define UART_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_core #(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       mclkx16,
  input  logic       reset,
  input  logic       rx,
  output logic       tx,
  uart_core_if.slave bus
);

`ifdef UART_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_LOAD  = 2'd1;
  localparam logic [1:0] TX_SHIFT = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_PAR   = 3'd3;
  localparam logic [2:0] RX_STOP  = 3'd4;

  // ---------------- transmitter ----------------
  logic [1:0]    tx_st;
  logic [7:0]    tx_hold;
  logic [NB-1:0] tx_sr;
  logic [NB-1:0] tx_frame;
  logic [3:0]    tx_tick;
  logic [3:0]    tx_bitn;

`ifdef UART_PARITY_EN
  assign tx_frame = {(^tx_hold) ^ PARITY_ODD, tx_hold};
`else
  assign tx_frame = tx_hold;
`endif

  // The byte is latched while write is low; the frame starts only once write
  // returns high, so a long strobe cannot re-trigger a capture.
  always_ff @(posedge mclkx16) begin
    if (!reset) begin
      tx_st     <= TX_IDLE;
      tx_hold   <= '0;
      tx_sr     <= '0;
      tx_tick   <= '0;
      tx_bitn   <= '0;
      tx        <= 1'b1;
      bus.txrdy <= 1'b1;
    end else begin
      case (tx_st)
        TX_IDLE: begin
          if (bus.txrdy && !bus.write) begin
            tx_hold   <= bus.datain;
            bus.txrdy <= 1'b0;
          end else if (!bus.txrdy && bus.write) begin
            tx_st <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          tx      <= 1'b0;
          tx_sr   <= tx_frame;
          tx_tick <= '0;
          tx_bitn <= '0;
          tx_st   <= TX_SHIFT;
        end
        TX_SHIFT: begin
          tx_tick <= tx_tick + 4'd1;
          if (tx_tick == 4'd15) begin
            if (tx_bitn == 4'(NB)) begin
              tx    <= 1'b1;
              tx_st <= TX_STOP;
            end else begin
              tx      <= tx_sr[0];
              tx_sr   <= tx_sr >> 1;
              tx_bitn <= tx_bitn + 4'd1;
            end
          end
        end
        TX_STOP: begin
          tx_tick <= tx_tick + 4'd1;
          if (tx_tick == 4'd15) begin
            bus.txrdy <= 1'b1;
            tx_st     <= TX_IDLE;
          end
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  // rx_sync[1] is the synchronised line, rx_sync[2] its previous value.
  logic [2:0] rx_sync;
  logic       rx_s;
  logic       rx_prev;
  logic [2:0] rx_st;
  logic [7:0] rx_sr;
  logic [3:0] rx_tick;
  logic [2:0] rx_bitn;
  logic       mid;
  logic       stop_smp;
  logic       par_mis;

  assign rx_s     = rx_sync[1];
  assign rx_prev  = rx_sync[2];
  assign mid      = (rx_tick == 4'd8);
  assign stop_smp = (rx_st == RX_STOP) && mid;

`ifdef UART_PARITY_EN
  logic rx_pbit;
  assign par_mis = rx_pbit ^ (^rx_sr) ^ PARITY_ODD;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign par_mis = 1'b0;
`endif

  always_ff @(posedge mclkx16) begin
    if (!reset) begin
      rx_sync <= 3'b111;
      rx_st   <= RX_IDLE;
      rx_sr   <= '0;
      rx_tick <= '0;
      rx_bitn <= '0;
`ifdef UART_PARITY_EN
      rx_pbit <= 1'b0;
`endif
    end else begin
      rx_sync <= {rx_sync[1:0], rx};
      case (rx_st)
        RX_IDLE: begin
          rx_tick <= '0;
          if (rx_prev && !rx_s) rx_st <= RX_START;
        end
        RX_START: begin
          rx_tick <= rx_tick + 4'd1;
          if (mid) begin
            rx_bitn <= '0;
            rx_st   <= rx_s ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          rx_tick <= rx_tick + 4'd1;
          if (mid) begin
            rx_sr   <= {rx_s, rx_sr[7:1]};
            rx_bitn <= rx_bitn + 3'd1;
`ifdef UART_PARITY_EN
            if (rx_bitn == 3'd7) rx_st <= RX_PAR;
`else
            if (rx_bitn == 3'd7) rx_st <= RX_STOP;
`endif
          end
        end
        RX_PAR: begin
          rx_tick <= rx_tick + 4'd1;
          if (mid) begin
`ifdef UART_PARITY_EN
            rx_pbit <= rx_s;
`endif
            rx_st <= RX_STOP;
          end
        end
        RX_STOP: begin
          rx_tick <= rx_tick + 4'd1;
          if (mid) rx_st <= RX_IDLE;
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // Host-visible receive status; a stop sample takes priority over a read.
  always_ff @(posedge mclkx16) begin
    if (!reset) begin
      bus.dataout    <= '0;
      bus.rxrdy      <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.framingerr <= 1'b0;
      bus.parityerr  <= 1'b0;
    end else if (stop_smp) begin
      bus.dataout    <= rx_sr;
      bus.rxrdy      <= 1'b1;
      bus.framingerr <= !rx_s;
      bus.parityerr  <= par_mis;
      if (bus.rxrdy)     bus.overrun <= 1'b1;
      else if (!bus.read) bus.overrun <= 1'b0;
    end else if (!bus.read) begin
      bus.rxrdy   <= 1'b0;
      bus.overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: directed stimulus pushes expected frames,
// a monitor pops and compares whenever rxrdy or overrun rises.
module tb_uart_core;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic rx_drv;
  logic loop;
  logic rx;
  logic tx;
  int   checks = 0;
  int   errors = 0;

  uart_core_if bus();

  assign rx = loop ? tx : rx_drv;

  uart_core #(.PARITY_ODD(1'b0)) dut (
    .mclkx16 (clk),
    .reset   (rst_n),
    .rx      (rx),
    .tx      (tx),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic prev_rdy = 1'b0;
  logic prev_ov  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
    exp_t x;
    x.d = d; x.pe = pe; x.fe = fe; x.ov = ov;
    q.push_back(x);
  endtask

  // Monitor: one expected frame per rxrdy rise or overrun rise.
  always @(negedge clk) begin
    if (rst_n && ((bus.rxrdy && !prev_rdy) || (bus.overrun && !prev_ov))) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got dataout %0h with empty queue", bus.dataout);
      end else begin
        e = q.pop_front();
        chk("rx_dataout",    {24'h0, bus.dataout}, {24'h0, e.d});
        chk("rx_parityerr",  {31'h0, bus.parityerr}, {31'h0, e.pe});
        chk("rx_framingerr", {31'h0, bus.framingerr}, {31'h0, e.fe});
        chk("rx_overrun",    {31'h0, bus.overrun}, {31'h0, e.ov});
      end
    end
    prev_rdy <= bus.rxrdy;
    prev_ov  <= bus.overrun;
  end

  task automatic wait_txrdy();
    int n = 0;
    while (!bus.txrdy && n < 400) begin @(negedge clk); n++; end
    if (!bus.txrdy) begin
      checks++; errors++;
      $display("FAIL txrdy_timeout: got txrdy 0 expected 1");
    end
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!bus.rxrdy && n < 400) begin @(negedge clk); n++; end
    if (!bus.rxrdy) begin
      checks++; errors++;
      $display("FAIL rxrdy_timeout: got rxrdy 0 expected 1");
    end
  endtask

  task automatic do_write(input logic [7:0] b);
    wait_txrdy();
    @(negedge clk);
    bus.datain = b;
    bus.write  = 1'b0;
    @(negedge clk);
    bus.write  = 1'b1;
  endtask

  task automatic do_read();
    @(negedge clk);
    bus.read = 1'b0;
    @(negedge clk);
    bus.read = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb, input logic badpar);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (16) @(negedge clk);
    end
    if (PAR_EN) begin
      rx_drv = (^b) ^ badpar;
      repeat (16) @(negedge clk);
    end
    rx_drv = stopb;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got no finish expected finish before 3ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int wave[$];
    int n;
    int mism;
    rst_n = 1'b0; rx_drv = 1'b1; loop = 1'b0;
    bus.read = 1'b1; bus.write = 1'b1; bus.datain = 8'h00;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_tx",         {31'h0, tx}, 32'h1);
    chk("rst_txrdy",      {31'h0, bus.txrdy}, 32'h1);
    chk("rst_rxrdy",      {31'h0, bus.rxrdy}, 32'h0);
    chk("rst_dataout",    {24'h0, bus.dataout}, 32'h0);
    chk("rst_parityerr",  {31'h0, bus.parityerr}, 32'h0);
    chk("rst_framingerr", {31'h0, bus.framingerr}, 32'h0);
    chk("rst_overrun",    {31'h0, bus.overrun}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // loopback sweep
    loop = 1'b1;
    for (int v = 0; v <= 8'h86; v++) begin
      push_exp(v[7:0], 1'b0, 1'b0, 1'b0);
      do_write(v[7:0]);
      wait_rdy();
      do_read();
      chk("sweep_rxrdy_clr", {31'h0, bus.rxrdy}, 32'h0);
      chk("sweep_dataout_hold", {24'h0, bus.dataout}, v);
    end

    // tx waveform for 8'hA5
    wave = '{0, 1, 0, 1, 0, 0, 1, 0, 1};
    if (PAR_EN) wave.push_back(0);
    wave.push_back(1);
    push_exp(8'hA5, 1'b0, 1'b0, 1'b0);
    do_write(8'hA5);
    n = 0;
    while (tx && n < 10) begin @(negedge clk); n++; end
    chk("txw_start_seen", {31'h0, tx}, 32'h0);
    foreach (wave[k]) begin
      mism = 0;
      for (int c = 0; c < 16; c++) begin
        if (tx !== wave[k][0] || bus.txrdy !== 1'b0) mism++;
        @(negedge clk);
      end
      chk($sformatf("txw_bit%0d_mismatch_cycles", k), mism, 0);
    end
    chk("txw_txrdy_after_stop", {31'h0, bus.txrdy}, 32'h1);
    wait_rdy();
    do_read();

    // reset mid-frame
    loop = 1'b0;
    do_write(8'h0F);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_tx",    {31'h0, tx}, 32'h1);
    chk("midrst_txrdy", {31'h0, bus.txrdy}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // overrun
    push_exp(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    push_exp(8'h22, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("ovr_flag",    {31'h0, bus.overrun}, 32'h1);
    chk("ovr_dataout", {24'h0, bus.dataout}, 32'h22);
    do_read();
    chk("ovr_clr_overrun", {31'h0, bus.overrun}, 32'h0);
    chk("ovr_clr_rxrdy",   {31'h0, bus.rxrdy}, 32'h0);

    // framing + parity error, then a clean frame
    push_exp(8'h3C, PAR_EN, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    wait_rdy();
    chk("ferr_flag", {31'h0, bus.framingerr}, 32'h1);
    do_read();
    push_exp(8'h7E, 1'b0, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0);
    wait_rdy();
    chk("clean_framingerr", {31'h0, bus.framingerr}, 32'h0);
    chk("clean_parityerr",  {31'h0, bus.parityerr}, 32'h0);
    do_read();

    // false start glitch
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    chk("fstart_no_rxrdy", {31'h0, bus.rxrdy}, 32'h0);
    push_exp(8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_rdy();
    do_read();

    repeat (8) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Full-duplex UART, 8 data bits, one stop bit, optional parity bit; all logic runs on a 16x-baud master clock.
- Transmitter accepts a parallel byte through an active-low write strobe and serialises it on tx. Receiver deserialises rx into a byte, flags rxrdy, and is drained through an active-low read strobe.
- Sits between a host parallel bus and an external serial line; rx and tx may be looped back for self-test.

Parameters:
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Used only when UART_PARITY_EN is defined.

Ports:
- mclkx16  in  1  master clock, 16x baud rate (153.6 kHz for 9600 baud)
- reset  in  1  synchronous, active-low reset, sampled on rising mclkx16
- rx  in  1  serial receive input, idle high
- read  in  1  active-low read strobe; clears rxrdy and overrun
- rxrdy  out  1  received byte available on dataout
- dataout  out  8  last received byte
- parityerr  out  1  parity mismatch in last frame
- framingerr  out  1  stop bit sampled low in last frame
- overrun  out  1  frame completed while rxrdy still set
- write  in  1  active-low write strobe
- datain  in  8  byte to transmit
- txrdy  out  1  transmitter idle, ready for a new write
- tx  out  1  serial transmit output, idle high

Behaviour:
- Reset (reset=0 at a clock edge) forces: tx=1, txrdy=1, rxrdy=0, dataout=0, parityerr=0, framingerr=0, overrun=0. Both FSMs go to IDLE.
- Reset mid-frame aborts the frame. tx returns high on the next cycle.
- Frame format: start bit 0, d[0]..d[7] LSB first, parity bit (if enabled), stop bit 1. Each bit lasts 16 clocks.
- rx is double-registered before use.
- TX FSM states: IDLE, LOAD, SHIFT, STOP.
  - IDLE: on any cycle with write=0 and txrdy=1, capture datain into the holding register and drive txrdy=0.
  - On the first cycle write is sampled 1 again, enter LOAD. The start bit begins on tx on the following cycle.
  - SHIFT: one bit per 16 clocks.
  - STOP: tx=1 for 16 clocks, then txrdy=1 and return to IDLE.
  - Writes while txrdy=0 are ignored. write must be held low for at least 1 clock.
- RX FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: a synchronised rx falling edge enters START.
  - START: at tick 8, if rx=0 continue to DATA, else it is a false start and the FSM returns to IDLE.
  - DATA and PAR: each bit is sampled at tick 8 of its 16-clock cell.
  - STOP: at the tick-8 sample, load dataout, set rxrdy=1, set framingerr=(rx==0), and set parityerr=parity mismatch. If rxrdy was already 1, set overrun=1 and overwrite dataout anyway.
  - Return to IDLE immediately after the stop sample, so back-to-back frames are accepted.
- read=0 sampled at a clock edge clears rxrdy and overrun on the next cycle. dataout is unaffected and stays valid.
- parityerr and framingerr hold until the next stop sample.
- If a stop sample and read=0 occur in the same cycle, the stop sample wins: rxrdy=1.
- End-to-end latency: from write rising edge to rxrdy in loopback is about 9.5 + P bit times (P=1 with parity, 0 without). Exact value is 2 + 16*(9+P) + 8 ±2 clocks.

Optional Feature:
- Macro UART_PARITY_EN.
  - Defined: 11-bit frame; parity bit generated per PARITY_ODD on tx and checked on rx; parityerr active.
  - Not defined: 10-bit frame with no parity bit; parityerr tied to 0; PARITY_ODD ignored.

Test Plan:
- Reset: hold reset=0 for 2 clocks -> tx=1, txrdy=1, rxrdy=0, dataout=8'h00, all error flags 0.
- Loopback sweep (rx=tx): for each value 8'h00..8'h86, write datain (write low 1 clock), wait for rxrdy rising, pulse read low -> dataout equals the written byte, parityerr=0, framingerr=0, rxrdy cleared after read.
- TX waveform: write 8'hA5 with even parity -> tx shows start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1, each exactly 16 clocks; txrdy low throughout, high after the stop bit.
- Overrun: receive 8'h11 without reading, then 8'h22 -> overrun=1, dataout=8'h22; read low -> overrun=0, rxrdy=0.
- Framing/parity error: drive an rx frame for 8'h3C with stop bit 0 and wrong parity -> framingerr=1, parityerr=1, rxrdy=1. A following clean frame clears both flags.
- False start: rx low pulse of 4 clocks -> no rxrdy; receiver returns to IDLE and then correctly receives 8'h5A.
